mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Multicycle load/store controller between the CPU datapath and the 4-lane byte-wide data RAM.
- Accepts one load or store request per transaction and decodes RISC-V funct3 (byte/half/word, signed/unsigned).
- Drives the RAM's four byte indices, four write bytes and its level-sensitive write enable; returns sign/zero-extended load data or completion status.
- Partial stores use read-modify-write, because the RAM writes all four lanes whenever its write enable is high.

Parameters:
- MEM_SIZE, 1024: RAM depth in bytes. Legal byte addresses are 0..MEM_SIZE-1.
- ENTRY_WIDTH, 8: RAM lane width. Fixed at 8; any other value is unsupported.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit idle, request accepted when req_valid&&req_ready
- req_we  input  1  1=store, 0=load
- req_funct3  input  3  RISC-V load/store funct3
- req_addr  input  32  byte address
- req_wdata  input  32  store data; low bytes used for SB/SH
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load data (0 for stores/errors)
- resp_err  output  1  request rejected, RAM untouched
- resp_cause  output  2  01 misaligned, 10 out of range, 11 illegal funct3, 00 ok
- ram_wr_en  output  1  to RAM wr_en
- ram_index0..3  output  32 each  to RAM index0..3
- ram_entry0..3  output  8 each  to RAM entry0..3
- ram_entry_out0..3  input  8 each  from RAM entry_out0..3

Behaviour:
- Clock and reset: single clock domain. All outputs are registered.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, resp_cause=0, ram_wr_en=0, all ram_index=0, all ram_entry=0.
- Lane mapping: ram_index k = req_addr+k, k=0..3, little-endian. Lane k carries byte k of the word.
- States:
  - IDLE: req_ready=1. On accept, latch we/funct3/addr/wdata and check errors.
    - Error → RESP with resp_err=1.
    - No error → READ: drive indices, ram_wr_en=0.
  - READ → CAPTURE (RAM read settles over one full cycle).
  - CAPTURE: register ram_entry_out0..3.
    - Load → RESP.
    - Store → WRITE: ram_entry = merged bytes (new bytes in written lanes, captured bytes elsewhere).
  - WRITE: ram_wr_en=1 for exactly one cycle → RESP. Indices and entries stay stable through WRITE.
  - RESP: resp_valid=1 for one cycle → IDLE. ram_wr_en is 0 in every state except WRITE.
- Latency (accept edge to resp_valid high):
  - Load: 3 cycles.
  - Store: 4 cycles.
  - Error: 1 cycle.
  - Back-to-back accept is possible the cycle after RESP.
- req_ready is 0 outside IDLE. Requests presented while busy are ignored (no queueing).
- funct3 decoding:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Signed forms sign-extend from bit 7/15; unsigned forms zero-extend.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Error checks, priority illegal > out-of-range > misaligned:
  - Out of range: req_addr+size-1 ≥ MEM_SIZE, where size is 1/2/4. Compute in 33 bits so 0xFFFFFFFF does not wrap.
  - Misaligned: see Optional Feature.
  - On error, resp_rdata=0 and no RAM write occurs.
- Bounds handling: unused lane indices for near-top in-range byte/half accesses are clamped to MEM_SIZE-1 so the RAM never sees an out-of-range index.
- ram_index holds its last value in IDLE, to avoid spurious RAM events.
- Reset mid-transaction: the next edge forces IDLE and all outputs to reset values, with no resp_valid. A write already strobed in WRITE remains in RAM.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: a half access with addr[0]≠0, or a word access with addr[1:0]≠0, yields resp_err=1, resp_cause=01.
- Undefined: misaligned accesses are performed normally across consecutive byte lanes, and cause 01 is never produced.

Test Plan:
- SW addr=0x10, wdata=0xDEADBEEF, then LW 0x10 → resp_rdata=0xDEADBEEF. Store resp_valid 4 cycles after accept, load 3 cycles after.
- After the SW above, SB addr=0x11 wdata=0x000000AA, then LW 0x10 → 0xDEADAAEF. LB 0x11 → 0xFFFFFFAA; LBU 0x11 → 0x000000AA.
- SH 0x12 wdata=0x8001, then LH 0x12 → 0xFFFF8001 and LHU 0x12 → 0x00008001. Bytes 0x10/0x11 unchanged.
- LW addr=MEM_SIZE-2 → resp_err=1, cause=10, 1-cycle latency, ram_wr_en never high. funct3=011 → cause 11. SB with req_addr=0xFFFFFFFF → cause 10.
- LW addr=0x13:
  - With MEM_ALIGN_CHECK_EN: cause=01.
  - Without: returns bytes 0x13..0x16 assembled little-endian.
- Assert reset during WRITE of an SW → next cycle state IDLE, ram_wr_en=0, no resp_valid. A following request is accepted normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Purpose: multicycle load/store controller for a 4-lane byte-wide RAM; partial stores are read-modify-write.
// Latency: accept to resp_valid is 3 cycles for a load, 4 for a store, 1 for a rejected request.
// Backpressure: req_ready is high only in IDLE; requests presented while busy are ignored.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned half/word accesses (cause 01).
module mem_access_unit #(
    parameter int MEM_SIZE    = 1024,
    parameter int ENTRY_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [2:0]             req_funct3,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_wdata,
    output logic                   resp_valid,
    output logic [31:0]            resp_rdata,
    output logic                   resp_err,
    output logic [1:0]             resp_cause,
    output logic                   ram_wr_en,
    output logic [31:0]            ram_index0,
    output logic [31:0]            ram_index1,
    output logic [31:0]            ram_index2,
    output logic [31:0]            ram_index3,
    output logic [ENTRY_WIDTH-1:0] ram_entry0,
    output logic [ENTRY_WIDTH-1:0] ram_entry1,
    output logic [ENTRY_WIDTH-1:0] ram_entry2,
    output logic [ENTRY_WIDTH-1:0] ram_entry3,
    input  logic [ENTRY_WIDTH-1:0] ram_entry_out0,
    input  logic [ENTRY_WIDTH-1:0] ram_entry_out1,
    input  logic [ENTRY_WIDTH-1:0] ram_entry_out2,
    input  logic [ENTRY_WIDTH-1:0] ram_entry_out3
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_RESP
    } state_t;

    localparam logic [32:0] LP_MEM_SIZE = 33'(MEM_SIZE);
    localparam logic [32:0] LP_TOP      = 33'(MEM_SIZE - 1);

    state_t      r_state;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_wdata;
    logic [3:0]  r_mask;
    logic [3:1]  r_clamp;

    logic        w_illegal;
    logic        w_oor;
    logic        w_misalign;
    logic        w_err;
    logic [1:0]  w_cause;
    logic [32:0] w_size;
    logic [32:0] w_last;
    logic [32:0] w_sum;
    logic [3:0]  w_mask_in;
    logic [3:0]  w_clamp_in;
    logic [31:0] w_idx [4];

    logic [7:0]  w_old [4];
    logic [7:0]  w_base [4];
    logic [7:0]  w_merged [4];
    logic [31:0] w_word;
    logic [31:0] w_rdata;

    // Decode the incoming request: legality, size, range, alignment and clamped lane indices.
    always_comb begin
        w_illegal = req_we ? (req_funct3 > 3'b010)
                           : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
        case (req_funct3[1:0])
            2'b00:   begin w_size = 33'd1; w_mask_in = 4'b0001; end
            2'b01:   begin w_size = 33'd2; w_mask_in = 4'b0011; end
            default: begin w_size = 33'd4; w_mask_in = 4'b1111; end
        endcase
        // 33-bit sum so an address near 0xFFFFFFFF cannot wrap back into range
        w_last = {1'b0, req_addr} + w_size - 33'd1;
        w_oor  = (w_last >= LP_MEM_SIZE);
`ifdef MEM_ALIGN_CHECK_EN
        w_misalign = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                     (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
        w_misalign = 1'b0;
`endif
        if (w_illegal)       w_cause = 2'b11;
        else if (w_oor)      w_cause = 2'b10;
        else if (w_misalign) w_cause = 2'b01;
        else                 w_cause = 2'b00;
        w_err = (w_cause != 2'b00);
        // Lanes past the top of memory (unused by an in-range access) are pinned to the last byte
        w_sum      = 33'd0;
        w_clamp_in = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            w_sum = {1'b0, req_addr} + 33'(k);
            if (w_sum > LP_TOP) begin
                w_idx[k]      = LP_TOP[31:0];
                w_clamp_in[k] = 1'b1;
            end else begin
                w_idx[k] = w_sum[31:0];
            end
        end
    end

    // Merge store bytes with captured RAM bytes and build extended load data.
    always_comb begin
        w_old[0] = ram_entry_out0;
        w_old[1] = ram_entry_out1;
        w_old[2] = ram_entry_out2;
        w_old[3] = ram_entry_out3;
        for (int k = 0; k < 4; k++) begin
            w_base[k] = r_mask[k] ? r_wdata[8*k +: 8] : w_old[k];
        end
        // Clamped lanes alias the top byte, so they must carry the same byte as the lane that
        // really targets it; otherwise the simultaneous four-lane write would disagree.
        w_merged[0] = w_base[0];
        w_merged[1] = r_clamp[1] ? w_base[0] : w_base[1];
        w_merged[2] = r_clamp[2] ? w_merged[1] : w_base[2];
        w_merged[3] = r_clamp[3] ? w_merged[2] : w_base[3];
        w_word = {w_old[3], w_old[2], w_old[1], w_old[0]};
        case (r_funct3)
            3'b000:  w_rdata = {{24{w_word[7]}}, w_word[7:0]};
            3'b001:  w_rdata = {{16{w_word[15]}}, w_word[15:0]};
            3'b100:  w_rdata = {24'd0, w_word[7:0]};
            3'b101:  w_rdata = {16'd0, w_word[15:0]};
            default: w_rdata = w_word;
        endcase
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_funct3   <= 3'd0;
            r_wdata    <= 32'd0;
            r_mask     <= 4'd0;
            r_clamp    <= 3'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            resp_cause <= 2'b00;
            ram_wr_en  <= 1'b0;
            ram_index0 <= 32'd0;
            ram_index1 <= 32'd0;
            ram_index2 <= 32'd0;
            ram_index3 <= 32'd0;
            ram_entry0 <= '0;
            ram_entry1 <= '0;
            ram_entry2 <= '0;
            ram_entry3 <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        r_we      <= req_we;
                        r_funct3  <= req_funct3;
                        r_wdata   <= req_wdata;
                        r_mask    <= w_mask_in;
                        r_clamp   <= w_clamp_in[3:1];
                        if (w_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_cause <= w_cause;
                            resp_rdata <= 32'd0;
                            r_state    <= S_RESP;
                        end else begin
                            ram_index0 <= w_idx[0];
                            ram_index1 <= w_idx[1];
                            ram_index2 <= w_idx[2];
                            ram_index3 <= w_idx[3];
                            r_state    <= S_READ;
                        end
                    end
                end
                S_READ: r_state <= S_CAPTURE;
                S_CAPTURE: begin
                    if (r_we) begin
                        ram_entry0 <= w_merged[0];
                        ram_entry1 <= w_merged[1];
                        ram_entry2 <= w_merged[2];
                        ram_entry3 <= w_merged[3];
                        ram_wr_en  <= 1'b1;
                        r_state    <= S_WRITE;
                    end else begin
                        resp_rdata <= w_rdata;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_cause <= 2'b00;
                        r_state    <= S_RESP;
                    end
                end
                S_WRITE: begin
                    ram_wr_en  <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_cause <= 2'b00;
                    resp_rdata <= 32'd0;
                    r_state    <= S_RESP;
                end
                S_RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_cause <= 2'b00;
                    resp_rdata <= 32'd0;
                    req_ready  <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    resp_valid <= 1'b0;
                    ram_wr_en  <= 1'b0;
                    req_ready  <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
